// File: rtl/hazard_scoreboard.sv
// Forwarding and hazard-detection scoreboard beside decode: shadows in-flight producers
// with a result-ready countdown and derives forward selects, a decode stall and a stall counter.
`timescale 1ns/1ps
module hazard_scoreboard #(
    parameter  int REG_ADDR_WIDTH = 5,
    parameter  int STAGES         = 3,
    parameter  int LAT_WIDTH      = 2,
    localparam int SEL_WIDTH      = $clog2(STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      freeze,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_use_rs1,
    input  logic                      id_use_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_regwrite,
    input  logic [LAT_WIDTH-1:0]      id_lat,
    output logic [SEL_WIDTH-1:0]      fwd_a,
    output logic [SEL_WIDTH-1:0]      fwd_b,
    output logic                      hazard_stall,
    output logic [31:0]               stall_count
);

    typedef struct packed {
        logic [SEL_WIDTH-1:0] sel;
        logic                 haz;
    } fwd_t;

    // Index k-1 holds downstream position k; index 0 is the youngest producer.
    logic                      r_valid [STAGES];
    logic [REG_ADDR_WIDTH-1:0] r_rd    [STAGES];
    logic [LAT_WIDTH-1:0]      r_cnt   [STAGES];
    logic [31:0]               r_stall_count;

    fwd_t                      w_res_a;
    fwd_t                      w_res_b;
    logic                      w_stall;
    logic                      w_issue;
    logic [LAT_WIDTH-1:0]      w_lat;

    // Scanning oldest to youngest lets the youngest matching producer overwrite the result.
    function automatic fwd_t resolve(input logic [REG_ADDR_WIDTH-1:0] rs,
                                     input logic                      use_rs);
        fwd_t res;
        res = '0;
        if (use_rs && rs != '0) begin
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (r_valid[k] && r_rd[k] == rs) begin
                    if (r_cnt[k] == '0) begin
                        res.sel = SEL_WIDTH'(k + 1);
                        res.haz = 1'b0;
                    end else begin
                        res.sel = '0;
                        res.haz = 1'b1;
                    end
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_lat   = id_lat;
        w_res_a = resolve(id_rs1, id_use_rs1);
        w_res_b = resolve(id_rs2, id_use_rs2);
        w_stall = id_valid & ~flush & (w_res_a.haz | w_res_b.haz);
        w_issue = id_valid & id_regwrite & ~flush & ~w_stall;
        if (int'(id_lat) >= STAGES) begin
            w_lat = LAT_WIDTH'(STAGES - 1);
        end
    end

    assign fwd_a        = w_res_a.sel;
    assign fwd_b        = w_res_b.sel;
    assign hazard_stall = w_stall;
    assign stall_count  = r_stall_count;

    // NOTE: the records are only a few flops and their valid bits must clear on reset,
    // so the whole shadow is reset rather than just the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_rd[k]    <= '0;
                r_cnt[k]   <= '0;
            end
        end else if (!freeze) begin
            // NOTE: non-blocking assignments let every position read its neighbour's old value.
            r_valid[0] <= w_issue;
            r_rd[0]    <= w_issue ? id_rd : '0;
            r_cnt[0]   <= w_issue ? w_lat : '0;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_rd[k]    <= r_rd[k-1];
                r_cnt[k]   <= (r_cnt[k-1] == '0) ? '0 : r_cnt[k-1] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (!freeze && w_stall && r_stall_count != 32'hFFFF_FFFF) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: an age-based model of in-flight producers
// checked every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int STAGES         = 3;
    localparam int LAT_WIDTH      = 2;
    localparam int SEL_WIDTH      = $clog2(STAGES + 1);

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      freeze = 1'b0;
    logic                      flush = 1'b0;
    logic                      id_valid = 1'b0;
    logic [REG_ADDR_WIDTH-1:0] id_rs1 = '0;
    logic [REG_ADDR_WIDTH-1:0] id_rs2 = '0;
    logic                      id_use_rs1 = 1'b0;
    logic                      id_use_rs2 = 1'b0;
    logic [REG_ADDR_WIDTH-1:0] id_rd = '0;
    logic                      id_regwrite = 1'b0;
    logic [LAT_WIDTH-1:0]      id_lat = '0;
    logic [SEL_WIDTH-1:0]      fwd_a;
    logic [SEL_WIDTH-1:0]      fwd_b;
    logic                      hazard_stall;
    logic [31:0]               stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .STAGES        (STAGES),
        .LAT_WIDTH     (LAT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .freeze      (freeze),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_lat      (id_lat),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .hazard_stall(hazard_stall),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each issued producer remembers how many advancing edges had occurred before it
    // was issued; its position is the age since then and its result exists once age-1 >= lat.
    int     q_rd  [$];
    int     q_lat [$];
    int     q_t   [$];
    int     m_adv = 0;
    longint m_cnt = 0;

    function automatic void model_op(input int rs, input logic use_rs,
                                     output int fwd, output logic haz);
        int   best;
        logic rdy;
        int   pos;
        best = STAGES + 1;
        rdy  = 1'b0;
        foreach (q_rd[i]) begin
            pos = m_adv - q_t[i];
            if (pos >= 1 && pos <= STAGES && q_rd[i] != 0 && q_rd[i] == rs && pos < best) begin
                best = pos;
                rdy  = (pos - 1) >= q_lat[i];
            end
        end
        fwd = 0;
        haz = 1'b0;
        if (use_rs && rs != 0 && best <= STAGES) begin
            if (rdy) fwd = best;
            else     haz = 1'b1;
        end
    endfunction

    function automatic logic model_stall();
        int   fa, fb;
        logic ha, hb;
        model_op(int'(id_rs1), id_use_rs1, fa, ha);
        model_op(int'(id_rs2), id_use_rs2, fb, hb);
        return id_valid && !flush && (ha || hb);
    endfunction

    always @(negedge rst_n) begin
        q_rd.delete();
        q_lat.delete();
        q_t.delete();
        m_adv = 0;
        m_cnt = 0;
    end

    always @(posedge clk) begin
        logic st;
        if (rst_n && !freeze) begin
            st = model_stall();
            if (st && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (id_valid && id_regwrite && !flush && !st) begin
                q_rd.push_back(int'(id_rd));
                q_lat.push_back(int'(id_lat) >= STAGES ? STAGES - 1 : int'(id_lat));
                q_t.push_back(m_adv);
            end
            m_adv++;
            while (q_t.size() > 0 && m_adv - q_t[0] > STAGES) begin
                void'(q_rd.pop_front());
                void'(q_lat.pop_front());
                void'(q_t.pop_front());
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle when inputs and state are stable.
    always @(negedge clk) begin
        int   ea, eb;
        logic ha, hb;
        if (rst_n) begin
            model_op(int'(id_rs1), id_use_rs1, ea, ha);
            model_op(int'(id_rs2), id_use_rs2, eb, hb);
            check("model_fwd_a", 32'(fwd_a), 32'(ea));
            check("model_fwd_b", 32'(fwd_b), 32'(eb));
            check("model_stall", 32'(hazard_stall), 32'(id_valid && !flush && (ha || hb)));
            check("model_stall_count", stall_count, m_cnt[31:0]);
        end
    end

    task automatic drive(input logic v, input int rs1, input logic u1, input int rs2,
                         input logic u2, input int rd, input logic rw, input int lat);
        id_valid    = v;
        id_rs1      = REG_ADDR_WIDTH'(rs1);
        id_use_rs1  = u1;
        id_rs2      = REG_ADDR_WIDTH'(rs2);
        id_use_rs2  = u2;
        id_rd       = REG_ADDR_WIDTH'(rd);
        id_regwrite = rw;
        id_lat      = LAT_WIDTH'(lat);
        #1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1;
        check("reset_stall", 32'(hazard_stall), 0);
        check("reset_count", stall_count, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cycle();

        // ALU chain
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        cycle();
        drive(1, 5, 1, 0, 0, 8, 1, 0);
        check("alu_fwd_pos1", 32'(fwd_a), 1);
        check("alu_no_stall", 32'(hazard_stall), 0);
        cycle();
        drive(1, 5, 1, 8, 1, 9, 1, 0);
        check("alu_fwd_pos2", 32'(fwd_a), 2);
        check("alu_fwd_b_pos1", 32'(fwd_b), 1);
        cycle();
        idle(3);

        // Load-use: exactly one bubble
        drive(1, 0, 0, 0, 0, 6, 1, 1);
        cycle();
        drive(1, 0, 0, 6, 1, 10, 1, 0);
        check("lu_stall", 32'(hazard_stall), 1);
        check("lu_fwd_b_held", 32'(fwd_b), 0);
        cycle();
        check("lu_release", 32'(hazard_stall), 0);
        check("lu_fwd_b_pos2", 32'(fwd_b), 2);
        check("lu_count", stall_count, 1);
        cycle();
        idle(3);

        // Priority, use flag and x0
        drive(1, 0, 0, 0, 0, 7, 1, 0);
        cycle();
        drive(1, 0, 0, 0, 0, 11, 1, 0);
        cycle();
        drive(1, 0, 0, 0, 0, 7, 1, 0);
        cycle();
        drive(1, 7, 1, 7, 1, 12, 0, 0);
        check("prio_fwd_a", 32'(fwd_a), 1);
        check("prio_fwd_b", 32'(fwd_b), 1);
        drive(1, 7, 0, 7, 1, 12, 0, 0);
        check("unused_rs1", 32'(fwd_a), 0);
        check("used_rs2", 32'(fwd_b), 1);
        cycle();
        idle(3);
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        cycle();
        drive(1, 0, 1, 0, 1, 13, 1, 0);
        check("x0_no_stall", 32'(hazard_stall), 0);
        check("x0_no_fwd", 32'(fwd_a), 0);
        cycle();
        idle(3);

        // Freeze during a load-use stall, then flush
        drive(1, 0, 0, 0, 0, 12, 1, 1);
        cycle();
        freeze = 1'b1;
        drive(1, 12, 1, 0, 0, 13, 1, 0);
        check("frz_stall", 32'(hazard_stall), 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("frz_stall_hold", 32'(hazard_stall), 1);
            check("frz_count_hold", stall_count, 1);
        end
        freeze = 1'b0;
        flush  = 1'b1;
        #1;
        check("flush_kills_stall", 32'(hazard_stall), 0);
        cycle();
        flush = 1'b0;
        drive(1, 12, 1, 13, 1, 14, 1, 0);
        check("flush_fwd_load", 32'(fwd_a), 2);
        check("flush_bubble", 32'(fwd_b), 0);
        check("flush_no_stall", 32'(hazard_stall), 0);
        check("flush_count", stall_count, 1);
        cycle();
        idle(3);

        // Latency clamp: lat 3 behaves as 2
        drive(1, 0, 0, 0, 0, 14, 1, 3);
        cycle();
        drive(1, 14, 1, 0, 0, 15, 1, 0);
        check("clamp_stall1", 32'(hazard_stall), 1);
        cycle();
        check("clamp_stall2", 32'(hazard_stall), 1);
        check("clamp_fwd_held", 32'(fwd_a), 0);
        cycle();
        check("clamp_release", 32'(hazard_stall), 0);
        check("clamp_fwd_pos3", 32'(fwd_a), 3);
        check("clamp_count", stall_count, 3);
        cycle();
        idle(3);

        // Asynchronous reset in the middle of a stall
        drive(1, 0, 0, 0, 0, 6, 1, 1);
        cycle();
        drive(1, 6, 1, 6, 1, 10, 1, 0);
        check("rst_pre_stall", 32'(hazard_stall), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_stall", 32'(hazard_stall), 0);
        check("rst_async_fwd_a", 32'(fwd_a), 0);
        check("rst_async_fwd_b", 32'(fwd_b), 0);
        check("rst_async_count", stall_count, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cycle();
        check("post_rst_no_stall", 32'(hazard_stall), 0);
        check("post_rst_no_fwd", 32'(fwd_b), 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
